// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine: state encodings, product
// one-hot codes, default prices and the coin unit. Also used by the credit FSM.
package vend_pkg;

    localparam int unsigned CREDIT_W_DEF     = 3;
    localparam int unsigned TMO_W_DEF        = 8;
    localparam int unsigned PRICE_SNACK_DEF  = 3;
    localparam int unsigned PRICE_COFFEE_DEF = 3;
    localparam int unsigned PRICE_DRINK_DEF  = 4;
    localparam int unsigned PRICE_CANDY_DEF  = 2;

    // Value of one credit coin in currency units.
    localparam int unsigned COIN_UNIT = 10;

    localparam logic [3:0] SNACK  = 4'b0001;
    localparam logic [3:0] COFFEE = 4'b0010;
    localparam logic [3:0] DRINK  = 4'b0100;
    localparam logic [3:0] CANDY  = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4,
        S_DONE     = 3'd5
    } vend_state_t;

    // True when exactly one selection bit is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/vend_payout.sv
// Loadable coin down-counter driving the hopper pay_req/pay_ack handshake.
// Ports: clock, reset (async active-low), en (payout allowed this cycle),
// load/load_val (set remaining coins), pay_ack (hopper released a coin),
// pay_req (request one coin), empty (no coins remaining).
module vend_payout
    import vend_pkg::*;
#(
    parameter int unsigned CNT_W = CREDIT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pay_ack,
    output logic             pay_req,
    output logic             empty
);

    logic [CNT_W-1:0] count;

    // An accepted coin always clears pay_req for one cycle; the next cycle
    // re-raises it from the updated count, giving the one-cycle minimum gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            empty   <= 1'b1;
            pay_req <= 1'b0;
        end else if (load) begin
            count   <= load_val;
            empty   <= (load_val == '0);
            pay_req <= en && (load_val != '0);
        end else if (pay_req && pay_ack && (count != '0)) begin
            count   <= count - CNT_W'(1);
            empty   <= (count == CNT_W'(1));
            pay_req <= 1'b0;
        end else begin
            pay_req <= en && (count != '0);
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense controller behind the credit FSM: price check, motor sequencing
// with timeout, change/refund payout and credit-consumed notification.
// Ports: clock, reset (async active-low); credit, choice, start, cancel from
// the credit FSM; motor_done from the motor; pay_ack from the hopper.
// Outputs motor_req, pay_req, vend_ok, reject, clear_credit, fault, busy, state.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W     = CREDIT_W_DEF,
    parameter int unsigned PRICE_SNACK  = PRICE_SNACK_DEF,
    parameter int unsigned PRICE_COFFEE = PRICE_COFFEE_DEF,
    parameter int unsigned PRICE_DRINK  = PRICE_DRINK_DEF,
    parameter int unsigned PRICE_CANDY  = PRICE_CANDY_DEF,
    parameter int unsigned TMO_W        = TMO_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [3:0]          choice,
    input  logic                start,
    input  logic                cancel,
    input  logic                motor_done,
    input  logic                pay_ack,
    output logic [3:0]          motor_req,
    output logic                pay_req,
    output logic                vend_ok,
    output logic                reject,
    output logic                clear_credit,
    output logic                fault,
    output logic                busy,
    output logic [2:0]          state
);

    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    vend_state_t         state_q, state_d;
    logic [3:0]          choice_q, choice_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMO_W-1:0]    timer_q, timer_d;
    logic                fault_d, vend_ok_d, reject_d;
    logic [CREDIT_W-1:0] price;
    logic                load;
    logic [CREDIT_W-1:0] load_val;
    logic                pay_en;
    logic                pay_empty;

    // Price of the latched selection; invalid selections are rejected anyway.
    always_comb begin
        price = '0;
        case (choice_q)
            SNACK:   price = CREDIT_W'(PRICE_SNACK);
            COFFEE:  price = CREDIT_W'(PRICE_COFFEE);
            DRINK:   price = CREDIT_W'(PRICE_DRINK);
            CANDY:   price = CREDIT_W'(PRICE_CANDY);
            default: price = '0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        choice_d  = choice_q;
        credit_d  = credit_q;
        timer_d   = '0;
        fault_d   = fault;
        vend_ok_d = 1'b0;
        reject_d  = 1'b0;
        load      = 1'b0;
        load_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (cancel && (credit != '0)) begin
                    load     = 1'b1;
                    load_val = credit;
                    state_d  = S_REFUND;
                end else if (start) begin
                    if (fault) begin
                        reject_d = 1'b1;
                    end else begin
                        choice_d = choice;
                        credit_d = credit;
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (!is_onehot4(choice_q) || (credit_q < price)) begin
                    reject_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    load     = 1'b1;
                    load_val = credit_q - price;
                    state_d  = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                timer_d = (timer_q == TMO_MAX) ? timer_q : timer_q + TMO_W'(1);
                if (motor_done) begin
                    vend_ok_d = 1'b1;
                    state_d   = pay_empty ? S_DONE : S_CHANGE;
                end else if (timer_q == TMO_MAX) begin
                    // Motor stuck: nothing dispensed, return the whole credit.
                    fault_d  = 1'b1;
                    load     = 1'b1;
                    load_val = credit_q;
                    state_d  = S_REFUND;
                end
            end
            S_CHANGE, S_REFUND: begin
                if (pay_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Payout only runs in the cycles the FSM will spend in CHANGE/REFUND,
    // which keeps pay_req and motor_req mutually exclusive.
    assign pay_en = (state_d == S_CHANGE) || (state_d == S_REFUND);

    // State, latched request and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            choice_q     <= '0;
            credit_q     <= '0;
            timer_q      <= '0;
            motor_req    <= '0;
            vend_ok      <= 1'b0;
            reject       <= 1'b0;
            clear_credit <= 1'b0;
            fault        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            choice_q     <= choice_d;
            credit_q     <= credit_d;
            timer_q      <= timer_d;
            motor_req    <= (state_d == S_DISPENSE) ? choice_d : 4'd0;
            vend_ok      <= vend_ok_d;
            reject       <= reject_d;
            clear_credit <= (state_d == S_DONE);
            fault        <= fault_d;
            busy         <= (state_d != S_IDLE);
        end
    end

    assign state = state_q;

    vend_payout #(
        .CNT_W (CREDIT_W)
    ) u_payout (
        .clock    (clock),
        .reset    (reset),
        .en       (pay_en),
        .load     (load),
        .load_val (load_val),
        .pay_ack  (pay_ack),
        .pay_req  (pay_req),
        .empty    (pay_empty)
    );

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed testbench for vend_dispense_ctrl.
module tb_vend_dispense_ctrl;

    logic       clock;
    logic       reset;
    logic [2:0] credit;
    logic [3:0] choice;
    logic       start;
    logic       cancel;
    logic       motor_done;
    logic       pay_ack;
    logic [3:0] motor_req;
    logic       pay_req;
    logic       vend_ok;
    logic       reject;
    logic       clear_credit;
    logic       fault;
    logic       busy;
    logic [2:0] state;

    int vectors;
    int miscompares;

    vend_dispense_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .credit       (credit),
        .choice       (choice),
        .start        (start),
        .cancel       (cancel),
        .motor_done   (motor_done),
        .pay_ack      (pay_ack),
        .motor_req    (motor_req),
        .pay_req      (pay_req),
        .vend_ok      (vend_ok),
        .reject       (reject),
        .clear_credit (clear_credit),
        .fault        (fault),
        .busy         (busy),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Responds to each pay_req with a one-cycle pay_ack until clear_credit.
    task automatic run_payout(output int coins, output int clears, output int overlap);
        coins   = 0;
        clears  = 0;
        overlap = 0;
        for (int i = 0; i < 60 && clears == 0; i++) begin
            if (pay_req && motor_req != 4'd0) overlap++;
            if (pay_req) begin
                pay_ack = 1'b1;
                coins++;
            end else begin
                pay_ack = 1'b0;
            end
            tick();
            if (clear_credit) clears++;
        end
        pay_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({motor_req, pay_req, vend_ok, reject, clear_credit, fault, busy, state} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", {motor_req, pay_req, vend_ok, reject, clear_credit, fault, busy, state});
        end
        reset = 1'b1;
        tick();
        // Reset asserted in DISPENSE must drop motor_req with no clock edge.
        credit = 3'd3; choice = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (motor_req !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_pre_motor got=%b want=0001", motor_req);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (motor_req !== 4'd0 || busy !== 1'b0 || state !== 3'd0 || pay_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async got motor=%b busy=%b state=%0d want 0/0/0", motor_req, busy, state);
        end
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_vend_change();
        int coins, clears, overlap;
        int vend_seen;
        credit = 3'd5; choice = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL vend_check_state got=%0d want=1", state);
        end
        tick();
        vectors++;
        if (motor_req !== 4'b0001 || state !== 3'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL vend_motor got=%b state=%0d want=0001 state=2", motor_req, state);
        end
        for (int i = 0; i < 8; i++) tick();
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
        vectors++;
        if (vend_ok !== 1'b1 || motor_req !== 4'd0 || state !== 3'd3) begin
            miscompares++;
            $display("FAIL vend_done got ok=%b motor=%b state=%0d want 1/0000/3", vend_ok, motor_req, state);
        end
        vend_seen = 1;
        run_payout(coins, clears, overlap);
        vectors++;
        if (coins != 2 || clears != 1 || overlap != 0) begin
            miscompares++;
            $display("FAIL vend_change got coins=%0d clears=%0d overlap=%0d want 2/1/0", coins, clears, overlap);
        end
        tick();
        vectors++;
        if (state !== 3'd0 || busy !== 1'b0 || vend_ok !== 1'b0 || clear_credit !== 1'b0 || vend_seen != 1) begin
            miscompares++;
            $display("FAIL vend_idle got state=%0d busy=%b clr=%b want 0/0/0", state, busy, clear_credit);
        end
    endtask

    task automatic test_exact_credit();
        int clears;
        int pays;
        credit = 3'd2; choice = 4'b1000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
        vectors++;
        if (vend_ok !== 1'b1 || state !== 3'd5 || clear_credit !== 1'b1 || pay_req !== 1'b0) begin
            miscompares++;
            $display("FAIL exact_done got ok=%b state=%0d clr=%b pay=%b want 1/5/1/0", vend_ok, state, clear_credit, pay_req);
        end
        clears = 0; pays = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (clear_credit) clears++;
            if (pay_req) pays++;
        end
        vectors++;
        if (state !== 3'd0 || clears != 0 || pays != 0) begin
            miscompares++;
            $display("FAIL exact_idle got state=%0d clr=%0d pay=%0d want 0/0/0", state, clears, pays);
        end
    endtask

    task automatic test_insufficient();
        credit = 3'd3; choice = 4'b0100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (reject !== 1'b1 || motor_req !== 4'd0 || state !== 3'd0 || clear_credit !== 1'b0) begin
            miscompares++;
            $display("FAIL insufficient got rej=%b motor=%b state=%0d want 1/0000/0", reject, motor_req, state);
        end
        tick();
        vectors++;
        if (reject !== 1'b0 || motor_req !== 4'd0) begin
            miscompares++;
            $display("FAIL insufficient_pulse got rej=%b motor=%b want 0/0000", reject, motor_req);
        end
    endtask

    task automatic test_bad_choice();
        logic [3:0] bad [2];
        bad[0] = 4'b0011;
        bad[1] = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            credit = 3'd7; choice = bad[k]; start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            vectors++;
            if (reject !== 1'b1 || motor_req !== 4'd0 || state !== 3'd0) begin
                miscompares++;
                $display("FAIL bad_choice_%b got rej=%b motor=%b state=%0d want 1/0000/0", bad[k], reject, motor_req, state);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int coins, clears, overlap;
        credit = 3'd4; choice = 4'b1000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 255; i++) tick();
        vectors++;
        if (fault !== 1'b0 || motor_req !== 4'b1000 || state !== 3'd2) begin
            miscompares++;
            $display("FAIL timeout_early got fault=%b motor=%b state=%0d want 0/1000/2", fault, motor_req, state);
        end
        tick();
        vectors++;
        if (fault !== 1'b1 || motor_req !== 4'd0 || state !== 3'd4 || vend_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_fire got fault=%b motor=%b state=%0d want 1/0000/4", fault, motor_req, state);
        end
        run_payout(coins, clears, overlap);
        vectors++;
        if (coins != 4 || clears != 1 || overlap != 0) begin
            miscompares++;
            $display("FAIL timeout_refund got coins=%0d clears=%0d overlap=%0d want 4/1/0", coins, clears, overlap);
        end
        tick();
        credit = 3'd4; choice = 4'b1000; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (reject !== 1'b1 || state !== 3'd0 || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_reject got rej=%b state=%0d fault=%b want 1/0/1", reject, state, fault);
        end
        tick();
        vectors++;
        if (motor_req !== 4'd0 || state !== 3'd0 || reject !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_no_motor got motor=%b state=%0d rej=%b want 0000/0/0", motor_req, state, reject);
        end
    endtask

    task automatic test_cancel_priority();
        int coins, clears, motor_seen;
        logic [5:0] pattern;
        credit = 3'd2; choice = 4'b0001; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        vectors++;
        if (state !== 3'd4 || pay_req !== 1'b1) begin
            miscompares++;
            $display("FAIL cancel_refund got state=%0d pay=%b want 4/1", state, pay_req);
        end
        pay_ack = 1'b1;
        coins = 0; clears = 0; motor_seen = 0; pattern = '0;
        for (int i = 0; i < 6; i++) begin
            pattern[5-i] = pay_req;
            if (pay_req) coins++;
            if (motor_req != 4'd0) motor_seen++;
            tick();
            if (clear_credit) clears++;
        end
        pay_ack = 1'b0;
        vectors++;
        if (pattern !== 6'b101000 || coins != 2) begin
            miscompares++;
            $display("FAIL cancel_toggle got pattern=%b coins=%0d want 101000/2", pattern, coins);
        end
        vectors++;
        if (clears != 1 || motor_seen != 0 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL cancel_end got clr=%0d motor=%0d state=%0d want 1/0/0", clears, motor_seen, state);
        end
        credit = 3'd0; cancel = 1'b1;
        tick();
        cancel = 1'b0;
        vectors++;
        if (state !== 3'd0 || pay_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_zero got state=%0d pay=%b busy=%b want 0/0/0", state, pay_req, busy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        credit = '0; choice = '0; start = 1'b0; cancel = 1'b0;
        motor_done = 1'b0; pay_ack = 1'b0;
        test_reset();
        test_vend_change();
        test_exact_credit();
        test_insufficient();
        test_bad_choice();
        test_timeout();
        test_cancel_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
